// File: rtl/yarp_core_seq.sv
// rtl/yarp_core_seq.sv - multi-cycle sequencer for the YARP core
//
// Purpose: steps each instruction through FETCH -> DECODE -> EXEC -> [MEM] -> WB
// and raises the strobes the datapath needs in each step. It also counts
// retired instructions.
//
// Optional feature: define YARP_SEQ_ILLEGAL_TRAP_EN to send illegal opcodes to
// TRAP, where they wait for trap_clr_i. When it is undefined, an illegal opcode
// retires as a NOP.
//
// Ports:
//   clk, reset            core clock, synchronous active-high reset
//   imem_req_o/ready_i    instruction fetch handshake, imem_rdata_i fetched word
//   instr_o               instruction register feeding the decoder
//   op_i, rd_i            opcode / destination register from the decoder
//   dmem_req_o/we_o       data access request and write qualifier
//   dmem_ready_i          data access completes this cycle
//   alu_en_o, rf_wr_en_o, pc_en_o   execute, register write and PC update strobes
//   trap_o, trap_clr_i    illegal-instruction trap and its acknowledge
//   state_o               current state encoding
//   instret_o             retired-instruction counter
module yarp_core_seq (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  input  logic        imem_ready_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  input  logic [6:0]  op_i,
  input  logic [4:0]  rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  input  logic        dmem_ready_i,
  output logic        alu_en_o,
  output logic        rf_wr_en_o,
  output logic        pc_en_o,
  output logic        trap_o,
  input  logic        trap_clr_i,
  output logic [2:0]  state_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;

  state_t      state_q, state_d;
  logic [31:0] instr_q;
  logic [31:0] instret_q;
  logic [6:0]  op_q, op_d;
  logic        rd_zero_q, rd_zero_d;

  logic        imem_req_q;
  logic        dmem_req_q;
  logic        dmem_we_q;
  logic        alu_en_q;
  logic        rf_wr_en_q;
  logic        pc_en_q;
  logic        trap_q;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h03, 7'h67, 7'h23,
      7'h63, 7'h37, 7'h17, 7'h6F: is_legal = 1'b1;
      default:                    is_legal = 1'b0;
    endcase
  endfunction

  // Stores, branches, writes to x0 and illegal NOPs leave the register file alone.
  function automatic logic writes_rf(input logic [6:0] op, input logic rd_zero);
    writes_rf = is_legal(op) && (op != OP_STORE) && (op != OP_BRANCH) && !rd_zero;
  endfunction

  // The opcode and rd are captured in DECODE. Later states then do not depend
  // on the decoder holding its outputs steady.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rd_zero_d = rd_zero_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        op_d      = op_i;
        rd_zero_d = (rd_i == 5'd0);
        if (is_legal(op_i)) begin
          state_d = S_EXEC;
        end else begin
`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_WB;
`endif
        end
      end
      S_EXEC: begin
        state_d = ((op_q == OP_LOAD) || (op_q == OP_STORE)) ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (dmem_ready_i) state_d = S_WB;
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
        if (trap_clr_i) state_d = S_FETCH;
`else
        state_d = S_FETCH;
`endif
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Strobes are registered from the next state. Each strobe is therefore a
  // clean flop output that matches state_q in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_FETCH;
      instr_q    <= 32'd0;
      instret_q  <= 32'd0;
      op_q       <= 7'd0;
      rd_zero_q  <= 1'b1;
      imem_req_q <= 1'b1;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      alu_en_q   <= 1'b0;
      rf_wr_en_q <= 1'b0;
      pc_en_q    <= 1'b0;
      trap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_zero_q  <= rd_zero_d;
      if ((state_q == S_FETCH) && imem_ready_i) instr_q <= imem_rdata_i;
      if (state_q == S_WB) instret_q <= instret_q + 32'd1;
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      dmem_we_q  <= (state_d == S_MEM) && (op_d == OP_STORE);
      alu_en_q   <= (state_d == S_EXEC);
      rf_wr_en_q <= (state_d == S_WB) && writes_rf(op_d, rd_zero_d);
      pc_en_q    <= (state_d == S_WB);
`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
      trap_q     <= (state_d == S_TRAP);
`else
      trap_q     <= 1'b0;
`endif
    end
  end

  // Reset is synchronous. Outputs are also masked by reset itself, so they
  // read 0 from the first cycle of reset, before the flops are cleared.
  assign imem_req_o = imem_req_q & ~reset;
  assign dmem_req_o = dmem_req_q & ~reset;
  assign dmem_we_o  = dmem_we_q  & ~reset;
  assign alu_en_o   = alu_en_q   & ~reset;
  assign rf_wr_en_o = rf_wr_en_q & ~reset;
  assign pc_en_o    = pc_en_q    & ~reset;
  assign state_o    = reset ? 3'd0 : state_q;
  assign instr_o    = instr_q   & {32{~reset}};
  assign instret_o  = instret_q & {32{~reset}};

`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
  assign trap_o = trap_q & ~reset;
`else
  logic unused_trap;
  assign unused_trap = trap_clr_i | trap_q;
  assign trap_o      = 1'b0;
`endif

endmodule

// File: tb/tb_yarp_core_seq.sv
// tb/tb_yarp_core_seq.sv - scoreboard bench for yarp_core_seq
module tb_yarp_core_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_o;
  logic        imem_ready_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [6:0]  op_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic        dmem_ready_i;
  logic        alu_en_o;
  logic        rf_wr_en_o;
  logic        pc_en_o;
  logic        trap_o;
  logic        trap_clr_i;
  logic [2:0]  state_o;
  logic [31:0] instret_o;

  yarp_core_seq dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req_o   (imem_req_o),
    .imem_ready_i (imem_ready_i),
    .imem_rdata_i (imem_rdata_i),
    .instr_o      (instr_o),
    .op_i         (op_i),
    .rd_i         (rd_i),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_ready_i (dmem_ready_i),
    .alu_en_o     (alu_en_o),
    .rf_wr_en_o   (rf_wr_en_o),
    .pc_en_o      (pc_en_o),
    .trap_o       (trap_o),
    .trap_clr_i   (trap_clr_i),
    .state_o      (state_o),
    .instret_o    (instret_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rf;
    logic [31:0] instret;
  } sb_item_t;

  sb_item_t    sb_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          wb_seen  = 0;
  int          wb_model = 0;
  logic [31:0] model_instret = 32'd0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {imem_req_o, dmem_req_o, dmem_we_o, alu_en_o, rf_wr_en_o, pc_en_o,
            trap_o, state_o} | instr_o | instret_o;
  endfunction

  function automatic logic op_legal(input logic [6:0] op);
    return op inside {7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
  endfunction

  // Scoreboard consumer: each WB cycle retires the oldest expected instruction.
  always @(negedge clk) begin
    if (pc_en_o) begin
      wb_seen++;
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_wb", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check_eq("sb_rf_wr_en", {31'd0, rf_wr_en_o}, {31'd0, it.rf});
        check_eq("sb_instret_in_wb", instret_o, it.instret);
      end
    end
  end

  // Runs one instruction from FETCH to the next FETCH. The caller supplies the
  // expected state trace (one nibble per cycle) and the strobe counts.
  task automatic do_instr(input string name, input logic [6:0] op, input logic [4:0] rd,
                          input int dly, input bit spur, input logic [31:0] exp_trace,
                          input int exp_dreq, input int exp_we, input int exp_rfw);
    logic [31:0] rdata;
    logic [31:0] trace = 32'd0;
    int dreq_n = 0, we_n = 0, rfw_n = 0, mem_cyc = 0, trap_cyc = 0, cyc = 0;
    bit done = 1'b0;
    bit legal;
    legal = op_legal(op);
    rdata = {$urandom_range(0, 32'h1FF_FFFF), op};
`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
    if (legal) begin
`else
    begin
`endif
      sb_q.push_back('{rf: legal && op != 7'h23 && op != 7'h63 && rd != 5'd0,
                       instret: model_instret});
      model_instret = model_instret + 32'd1;
      wb_model++;
    end
    imem_ready_i = 1'b1;
    imem_rdata_i = rdata;
    op_i = op;
    rd_i = rd;
    while (!done && cyc < 60) begin
      trace = (trace << 4) | {29'd0, state_o};
      if (dmem_req_o) begin
        dreq_n++;
        if (dmem_we_o) we_n++;
      end
      if (rf_wr_en_o) rfw_n++;
      if (state_o == 3'd1) check_eq({name, "_instr"}, instr_o, rdata);
      dmem_ready_i = (state_o == 3'd3) ? (mem_cyc == dly) : spur;
      if (state_o == 3'd3) mem_cyc++;
      if (state_o == 3'd5) begin
        check_eq({name, "_trap_o"}, {31'd0, trap_o}, 32'd1);
        check_eq({name, "_trap_strobes"},
                 {26'd0, imem_req_o, dmem_req_o, dmem_we_o, alu_en_o, rf_wr_en_o, pc_en_o}, 32'd0);
        trap_cyc++;
        trap_clr_i = (trap_cyc == 3);
        if (trap_clr_i) done = 1'b1;
      end
      if (state_o == 3'd4) done = 1'b1;
      @(negedge clk);
      cyc++;
    end
    imem_ready_i = 1'b0;
    dmem_ready_i = 1'b0;
    trap_clr_i   = 1'b0;
    check_eq({name, "_timeout"}, {31'd0, done}, 32'd1);
    check_eq({name, "_trace"}, trace, exp_trace);
    check_eq({name, "_dmem_req"}, dreq_n, exp_dreq);
    check_eq({name, "_dmem_we"}, we_n, exp_we);
    check_eq({name, "_rf_wr_en"}, rfw_n, exp_rfw);
    check_eq({name, "_next_fetch"}, {29'd0, state_o}, 32'd0);
    check_eq({name, "_instret"}, instret_o, model_instret);
  endtask

  initial begin
    int mc;
    reset = 1'b1;
    imem_ready_i = 1'b0;
    imem_rdata_i = 32'd0;
    op_i = 7'd0;
    rd_i = 5'd0;
    dmem_ready_i = 1'b0;
    trap_clr_i = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("reset_outs_zero", all_outs(), 32'd0);
    reset = 1'b0;
    #1;
    check_eq("reset_imem_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("reset_state", {29'd0, state_o}, 32'd0);
    check_eq("reset_instret", instret_o, 32'd0);
    check_eq("reset_instr", instr_o, 32'd0);
    @(negedge clk);

    do_instr("add",    7'h33, 5'd5, 0, 1'b0, 32'h0124,     0, 0, 1);
    do_instr("load",   7'h03, 5'd3, 3, 1'b0, 32'h01233334, 4, 0, 1);
    do_instr("store",  7'h23, 5'd3, 0, 1'b0, 32'h01234,    1, 1, 0);
    do_instr("branch", 7'h63, 5'd7, 0, 1'b1, 32'h0124,     0, 0, 0);
    do_instr("add_x0", 7'h33, 5'd0, 0, 1'b1, 32'h0124,     0, 0, 0);
`ifdef YARP_SEQ_ILLEGAL_TRAP_EN
    do_instr("illegal", 7'h7F, 5'd4, 0, 1'b0, 32'h01555,   0, 0, 0);
`else
    do_instr("illegal", 7'h7F, 5'd4, 0, 1'b0, 32'h014,     0, 0, 0);
`endif

    // Reset in the middle of a load: abandon it with no WB and no count.
    imem_ready_i = 1'b1;
    op_i = 7'h03;
    rd_i = 5'd2;
    mc = 0;
    for (int i = 0; i < 30 && mc < 2; i++) begin
      if (state_o == 3'd3) mc++;
      if (mc < 2) @(negedge clk);
    end
    check_eq("rst_mem_reached", mc, 2);
    imem_ready_i = 1'b0;
    reset = 1'b1;
    #1;
    check_eq("rst_mem_outs_first", all_outs(), 32'd0);
    @(negedge clk);
    check_eq("rst_mem_outs_held", all_outs(), 32'd0);
    reset = 1'b0;
    model_instret = 32'd0;
    #1;
    check_eq("rst_mem_state", {29'd0, state_o}, 32'd0);
    check_eq("rst_mem_imem_req", {31'd0, imem_req_o}, 32'd1);
    check_eq("rst_mem_instret", instret_o, 32'd0);
    check_eq("rst_mem_no_wb", wb_seen, wb_model);
    @(negedge clk);

    do_instr("add_post_rst", 7'h13, 5'd1, 0, 1'b0, 32'h0124, 0, 0, 1);

    // Preload the counter at its top value and retire one instruction to wrap it.
    force dut.instret_q = 32'hFFFF_FFFF;
    #1;
    release dut.instret_q;
    model_instret = 32'hFFFF_FFFF;
    check_eq("preload_instret", instret_o, 32'hFFFF_FFFF);
    @(negedge clk);
    do_instr("add_wrap", 7'h33, 5'd9, 0, 1'b0, 32'h0124, 0, 0, 1);
    check_eq("wrap_to_zero", instret_o, 32'd0);

    repeat (2) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    check_eq("wb_total", wb_seen, wb_model);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
